// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM command-bus sequencer: arbiter states,
// SDRAM command encodings {CS_n,RAS_n,CAS_n,WE_n} and the refresh interval.
package sdram_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } state_t;

  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRSET      = 4'b0000;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;

  // 15 us at 50 MHz
  localparam logic [9:0] CNT_REF = 10'd750;

endpackage

// File: rtl/sdram_arbit_if.sv
// Source buses, grants and muxed SDRAM command port of the sequencer.
// slave = the arbiter, master = init/refresh/write/read controllers + pins.
interface sdram_arbit_if;
  logic        flag_init_end;
  logic [3:0]  init_cmd;
  logic [11:0] init_addr;
  logic [1:0]  init_bank;

  logic        aref_en;
  logic        aref_req;
  logic        flag_aref_end;
  logic [3:0]  aref_cmd;
  logic [11:0] aref_addr;

  logic        wr_req;
  logic        wr_en;
  logic        flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_addr;
  logic [1:0]  wr_bank;

  logic        rd_req;
  logic        rd_en;
  logic        flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [11:0] rd_addr;
  logic [1:0]  rd_bank;

  logic [3:0]  sdram_cmd;
  logic [11:0] sdram_addr;
  logic [1:0]  sdram_bank;

  modport slave (
    input  flag_init_end, init_cmd, init_addr, init_bank,
    input  flag_aref_end, aref_cmd, aref_addr,
    input  wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    input  rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    output aref_en, aref_req, wr_en, rd_en,
    output sdram_cmd, sdram_addr, sdram_bank
  );

  modport master (
    output flag_init_end, init_cmd, init_addr, init_bank,
    output flag_aref_end, aref_cmd, aref_addr,
    output wr_req, flag_wr_end, wr_cmd, wr_addr, wr_bank,
    output rd_req, flag_rd_end, rd_cmd, rd_addr, rd_bank,
    input  aref_en, aref_req, wr_en, rd_en,
    input  sdram_cmd, sdram_addr, sdram_bank
  );
endinterface

// File: rtl/sdram_aref_timer.sv
// Periodic refresh timer: free-runs once init is done and raises a
// non-queuing refresh request every CNT_REF cycles.
module sdram_aref_timer #(
  parameter logic [9:0] CNT_REF = sdram_pkg::CNT_REF
) (
  input  logic sclk,
  input  logic s_rst_n,
  input  logic i_run,
  input  logic i_clr,
  output logic o_aref_req
);

  logic [9:0] r_cnt_ref;
  logic       r_aref_req;
  logic       w_wrap;

  assign w_wrap = i_run && (r_cnt_ref == CNT_REF - 10'd1);

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_cnt_ref <= '0;
    end else if (!i_run || w_wrap) begin
      r_cnt_ref <= '0;
    end else begin
      r_cnt_ref <= r_cnt_ref + 10'd1;
    end
  end

  // A wrap coinciding with the clear must win, or that refresh would be lost.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_aref_req <= 1'b0;
    end else if (w_wrap) begin
      r_aref_req <= 1'b1;
    end else if (i_clr) begin
      r_aref_req <= 1'b0;
    end
  end

  assign o_aref_req = r_aref_req;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM command-bus sequencer: holds the bus for init, then grants it to
// refresh, write or read (fixed priority) and muxes the owner onto the pins.
module sdram_arbit #(
  parameter logic [9:0] CNT_REF = sdram_pkg::CNT_REF,
  parameter logic [3:0] NOP     = sdram_pkg::CMD_NOP
) (
  input  logic          sclk,
  input  logic          s_rst_n,
  sdram_arbit_if.slave  bus
);
  import sdram_pkg::*;

  state_t      r_state;
  state_t      w_next;
  logic        w_aref_req;
  logic        w_run;
  logic        w_clr;
  logic [3:0]  w_cmd;
  logic [11:0] w_addr;
  logic [1:0]  w_bank;

  assign w_run = (r_state != ST_INIT);
  assign w_clr = (r_state == ST_ARBIT) && w_aref_req;

  sdram_aref_timer #(
    .CNT_REF (CNT_REF)
  ) u_aref_timer (
    .sclk       (sclk),
    .s_rst_n    (s_rst_n),
    .i_run      (w_run),
    .i_clr      (w_clr),
    .o_aref_req (w_aref_req)
  );

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Every owner returns to ARBIT, so one idle cycle always separates grants.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:  if (bus.flag_init_end) w_next = ST_ARBIT;
      ST_ARBIT: begin
        if (w_aref_req)      w_next = ST_AREF;
        else if (bus.wr_req) w_next = ST_WRITE;
        else if (bus.rd_req) w_next = ST_READ;
      end
      ST_AREF:  if (bus.flag_aref_end) w_next = ST_ARBIT;
      ST_WRITE: if (bus.flag_wr_end)   w_next = ST_ARBIT;
      ST_READ:  if (bus.flag_rd_end)   w_next = ST_ARBIT;
      default:  w_next = ST_INIT;
    endcase
  end

  // NOP while reset is held, so the pins are quiet even though INIT muxes init_*.
  always_comb begin
    w_cmd  = NOP;
    w_addr = '0;
    w_bank = '0;
    if (s_rst_n) begin
      case (r_state)
        ST_INIT: begin
          w_cmd  = bus.init_cmd;
          w_addr = bus.init_addr;
          w_bank = bus.init_bank;
        end
        ST_AREF: begin
          w_cmd  = bus.aref_cmd;
          w_addr = bus.aref_addr;
        end
        ST_WRITE: begin
          w_cmd  = bus.wr_cmd;
          w_addr = bus.wr_addr;
          w_bank = bus.wr_bank;
        end
        ST_READ: begin
          w_cmd  = bus.rd_cmd;
          w_addr = bus.rd_addr;
          w_bank = bus.rd_bank;
        end
        default: begin
          w_cmd  = NOP;
          w_addr = '0;
          w_bank = '0;
        end
      endcase
    end
  end

  assign bus.aref_en    = (r_state == ST_AREF);
  assign bus.wr_en      = (r_state == ST_WRITE);
  assign bus.rd_en      = (r_state == ST_READ);
  assign bus.aref_req   = w_aref_req;
  assign bus.sdram_cmd  = w_cmd;
  assign bus.sdram_addr = w_addr;
  assign bus.sdram_bank = w_bank;

endmodule
